// File: rtl/ym_sr_cnt_ring.sv
// Time-multiplexed per-slot counter ring: SLOTS counters of WIDTH bits share one
// adder and circulate through a two-phase master/slave shift ring on MCLK.
module ym_sr_cnt_ring #(
    parameter int unsigned WIDTH  = 8,
    parameter int unsigned SLOTS  = 18,
    parameter int unsigned SAT    = 0,
    parameter int unsigned SLOT_W = 6
) (
    input  logic              MCLK,
    input  logic              rst_n,
    input  logic              c1,
    input  logic              c2,
    input  logic [WIDTH-1:0]  step,
    input  logic              sub,
    input  logic              load,
    input  logic [WIDTH-1:0]  load_val,
    input  logic              clr,
    input  logic              sync,
    output logic [WIDTH-1:0]  val,
    output logic              c_out,
    output logic [SLOT_W-1:0] slot,
    output logic              slot0
);

    localparam logic [SLOT_W-1:0] LAST_SLOT = SLOT_W'(SLOTS - 1);

    logic [SLOTS-1:0][WIDTH-1:0] m_q;
    logic [SLOTS-1:0][WIDTH-1:0] s_q;
    logic [SLOT_W-1:0]           slot_q;
    logic                        slot0_q;

    logic [WIDTH-1:0]  base_c;
    logic [WIDTH:0]    res_c;
    logic [WIDTH-1:0]  nxt_c;
    logic [SLOT_W-1:0] slot_nxt_c;

    // Shared head adder: carry/borrow lands in the extra top bit.
    always_comb begin
        base_c = load ? load_val : s_q[SLOTS-1];
        if (sub) begin
            res_c = {1'b0, base_c} - {1'b0, step};
        end else begin
            res_c = {1'b0, base_c} + {1'b0, step};
        end
        nxt_c = res_c[WIDTH-1:0];
        if ((SAT != 0) && res_c[WIDTH]) begin
            nxt_c = sub ? '0 : '1;
        end
        if (clr) begin
            nxt_c = '0;
        end
    end

    always_comb begin
        slot_nxt_c = slot_q + SLOT_W'(1);
        if (sync || (slot_q == LAST_SLOT)) begin
            slot_nxt_c = '0;
        end
    end

    // Master stage: head result enters entry 0, the rest shift up from the slave.
    always_ff @(posedge MCLK or negedge rst_n) begin
        if (!rst_n) begin
            m_q <= '0;
        end else if (c1) begin
            m_q <= {s_q[SLOTS-2:0], nxt_c};
        end
    end

    always_ff @(posedge MCLK or negedge rst_n) begin
        if (!rst_n) begin
            s_q     <= '0;
            slot_q  <= '0;
            slot0_q <= 1'b1;
        end else if (c2) begin
            s_q     <= m_q;
            slot_q  <= slot_nxt_c;
            slot0_q <= (slot_nxt_c == '0);
        end
    end

    assign val   = s_q[SLOTS-1];
    assign c_out = res_c[WIDTH];
    assign slot  = slot_q;
    assign slot0 = slot0_q;

endmodule
